// File: rtl/vibrometer_axi_pkg.sv
// rtl/vibrometer_axi_pkg.sv - shared AXI constants and writer FSM states
// Used by the AXI-Stream to DDR burst writer.
package vibrometer_axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - first-word fall-through stream FIFO with occupancy count
// Output data is read combinationally from the head entry, so a pushed word is visible next cycle.
module axis_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   s_tdata_i,
  input  logic               s_tvalid_i,
  output logic               s_tready_o,
  output logic [WIDTH-1:0]   m_tdata_o,
  output logic               m_tvalid_o,
  input  logic               m_tready_i,
  output logic [LOG_DEPTH:0] count_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 push, pop;

  // Ready is held low while reset is asserted so nothing is accepted into a clearing FIFO.
  assign s_tready_o = (count_q != DEPTH_CNT) && !rst_i;
  assign m_tvalid_o = (count_q != '0);
  assign m_tdata_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign push       = s_tvalid_i && s_tready_o;
  assign pop        = m_tvalid_o && m_tready_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (LOG_DEPTH+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (LOG_DEPTH+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LOG_DEPTH'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_tdata_i;
  end

endmodule

// File: rtl/axis_ram_writer.sv
// rtl/axis_ram_writer.sv - buffers a sample stream and writes fixed INCR bursts into a DDR ring buffer
// One burst is outstanding at a time; write_index commits only after the write response.
module axis_ram_writer
  import vibrometer_axi_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int BURST_LEN        = 16,
  parameter int LOG_FIFO_DEPTH   = 6
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [AXI_ADDR_WIDTH-1:0]     base_address,
  input  logic [4:0]                    log_length,
  output logic [31:0]                   write_index,
  output logic                          error,
  output logic                          S_AXIS_tready,
  input  logic                          S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  output logic [AXI_ID_WIDTH-1:0]       M_AXI_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [3:0]                    M_AXI_awlen,
  output logic [2:0]                    M_AXI_awsize,
  output logic [1:0]                    M_AXI_awburst,
  output logic [3:0]                    M_AXI_awcache,
  output logic                          M_AXI_awvalid,
  input  logic                          M_AXI_awready,
  output logic [AXI_ID_WIDTH-1:0]       M_AXI_wid,
  output logic [AXIS_TDATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                          M_AXI_wlast,
  output logic                          M_AXI_wvalid,
  input  logic                          M_AXI_wready,
  input  logic [1:0]                    M_AXI_bresp,
  input  logic                          M_AXI_bvalid,
  output logic                          M_AXI_bready
);

  localparam int BYTES   = AXIS_TDATA_WIDTH / 8;
  localparam int SIZE    = $clog2(BYTES);
  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int MIN_LOG = $clog2(BURST_LEN);
  localparam logic [LOG_FIFO_DEPTH:0] BURST_CNT = (LOG_FIFO_DEPTH+1)'(BURST_LEN);
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  wr_state_e                 state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [31:0]               index_q, index_d;
  logic [31:0]               mask_q, mask_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                      error_q, error_d;

  logic [AXIS_TDATA_WIDTH-1:0] fifo_tdata;
  logic                        fifo_tvalid, fifo_tready;
  logic [LOG_FIFO_DEPTH:0]     fifo_count;
  logic [4:0]                  eff_log;
  logic [31:0]                 byte_off;

  axis_sync_fifo #(
    .WIDTH     (AXIS_TDATA_WIDTH),
    .LOG_DEPTH (LOG_FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (aclk),
    .rst_i      (areset),
    .s_tdata_i  (S_AXIS_tdata),
    .s_tvalid_i (S_AXIS_tvalid),
    .s_tready_o (S_AXIS_tready),
    .m_tdata_o  (fifo_tdata),
    .m_tvalid_o (fifo_tvalid),
    .m_tready_i (fifo_tready),
    .count_o    (fifo_count)
  );

  // Buffer must hold at least one burst so the masked index never splits a burst.
  assign eff_log  = (log_length < 5'(MIN_LOG)) ? 5'(MIN_LOG) : log_length;
  assign byte_off = index_q << SIZE;

  assign M_AXI_awid    = '0;
  assign M_AXI_awaddr  = awaddr_q;
  assign M_AXI_awlen   = 4'(BURST_LEN - 1);
  assign M_AXI_awsize  = 3'(SIZE);
  assign M_AXI_awburst = AXI_BURST_INCR;
  assign M_AXI_awcache = AXI_CACHE_DEFAULT;
  assign M_AXI_wid     = '0;
  assign M_AXI_wdata   = fifo_tdata;
  assign M_AXI_wstrb   = '1;
  assign write_index   = index_q;
  assign error         = error_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    index_d       = index_q;
    mask_d        = mask_q;
    awaddr_d      = awaddr_q;
    error_d       = error_q;
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_wlast   = 1'b0;
    M_AXI_bready  = 1'b0;
    fifo_tready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && fifo_count >= BURST_CNT) begin
          state_d  = ADDR;
          beat_d   = '0;
          awaddr_d = base_address + AXI_ADDR_WIDTH'(byte_off);
          mask_d   = (32'd1 << eff_log) - 32'd1;
        end
      end
      ADDR: begin
        M_AXI_awvalid = 1'b1;
        if (M_AXI_awready) state_d = DATA;
      end
      DATA: begin
        // A full burst was buffered before leaving IDLE, so the FIFO cannot run dry here.
        M_AXI_wvalid = fifo_tvalid;
        M_AXI_wlast  = (beat_q == LAST_BEAT);
        fifo_tready  = M_AXI_wready;
        if (M_AXI_wready && fifo_tvalid) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        M_AXI_bready = 1'b1;
        if (M_AXI_bvalid) begin
          index_d = (index_q + 32'(BURST_LEN)) & mask_q;
          error_d = error_q | (M_AXI_bresp != AXI_RESP_OKAY);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      index_q  <= '0;
      mask_q   <= '0;
      awaddr_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      index_q  <= index_d;
      mask_q   <= mask_d;
      awaddr_q <= awaddr_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_axis_ram_writer.sv
// tb/tb_axis_ram_writer.sv - scoreboard bench for the stream to DDR ring-buffer writer
// Source, AXI slave and monitor run as separate processes; expected data flows through exp_mem.
module tb_axis_ram_writer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] base_address = 32'h1000_0000;
  logic [4:0]  log_length = 5'd8;
  logic [31:0] write_index;
  logic        error;
  logic        S_AXIS_tready;
  logic        S_AXIS_tvalid = 1'b0;
  logic [31:0] S_AXIS_tdata = '0;
  logic [5:0]  M_AXI_awid;
  logic [31:0] M_AXI_awaddr;
  logic [3:0]  M_AXI_awlen;
  logic [2:0]  M_AXI_awsize;
  logic [1:0]  M_AXI_awburst;
  logic [3:0]  M_AXI_awcache;
  logic        M_AXI_awvalid;
  logic        M_AXI_awready = 1'b0;
  logic [5:0]  M_AXI_wid;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_wlast;
  logic        M_AXI_wvalid;
  logic        M_AXI_wready = 1'b0;
  logic [1:0]  M_AXI_bresp = 2'b00;
  logic        M_AXI_bvalid = 1'b0;
  logic        M_AXI_bready;

  axis_ram_writer dut (
    .aclk(aclk), .areset(areset), .enable(enable), .base_address(base_address),
    .log_length(log_length), .write_index(write_index), .error(error),
    .S_AXIS_tready(S_AXIS_tready), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tdata(S_AXIS_tdata),
    .M_AXI_awid(M_AXI_awid), .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen),
    .M_AXI_awsize(M_AXI_awsize), .M_AXI_awburst(M_AXI_awburst), .M_AXI_awcache(M_AXI_awcache),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wid(M_AXI_wid), .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wlast(M_AXI_wlast), .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: burst k since reset lands at word (k*16) mod buffer size.
  function automatic logic [31:0] ring_word(input int bursts);
    int eff;
    eff = (int'(log_length) < 4) ? 4 : int'(log_length);
    return 32'((bursts * 16) % (1 << eff));
  endfunction

  logic [31:0] exp_mem [4096];
  int exp_wr = 0;
  int exp_rd = 0;

  // Knobs owned by the main sequence.
  int src_total = 0;
  bit src_rand = 1'b0;
  int src_gap_pct = 0;
  int aw_pct = 100;
  int w_pct = 100;
  bit w_hold = 1'b0;
  int err_burst = -1;

  // Stream source: keeps tvalid/tdata stable until accepted.
  int src_sent = 0;
  logic [31:0] src_seq = 32'd1;
  bit presenting = 1'b0;
  bit accepted = 1'b0;
  always begin
    @(negedge aclk);
    if (areset) begin
      S_AXIS_tvalid = 1'b0;
      presenting = 1'b0;
      accepted = 1'b0;
    end else begin
      if (accepted) begin
        presenting = 1'b0;
        S_AXIS_tvalid = 1'b0;
        accepted = 1'b0;
      end
      if (!presenting && src_sent < src_total && int'($urandom_range(99)) >= src_gap_pct) begin
        presenting = 1'b1;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata = src_rand ? $urandom : src_seq;
      end
      #1;
      if (presenting && S_AXIS_tready) begin
        exp_mem[exp_wr % 4096] = S_AXIS_tdata;
        exp_wr++;
        src_sent++;
        src_seq++;
        accepted = 1'b1;
      end
    end
  end

  // AXI slave: random ready, one write response per wlast.
  int slv_bursts = 0;
  bit b_pending = 1'b0;
  bit b_acc = 1'b0;
  always begin
    @(negedge aclk);
    if (areset) begin
      M_AXI_awready = 1'b0;
      M_AXI_wready = 1'b0;
      M_AXI_bvalid = 1'b0;
      M_AXI_bresp = 2'b00;
      b_pending = 1'b0;
      b_acc = 1'b0;
      slv_bursts = 0;
    end else begin
      if (b_acc) begin
        M_AXI_bvalid = 1'b0;
        b_acc = 1'b0;
        slv_bursts++;
      end
      M_AXI_awready = int'($urandom_range(99)) < aw_pct;
      M_AXI_wready = !w_hold && (int'($urandom_range(99)) < w_pct);
      if (b_pending && !M_AXI_bvalid) begin
        M_AXI_bvalid = 1'b1;
        M_AXI_bresp = (slv_bursts + 1 == err_burst) ? 2'b10 : 2'b00;
        b_pending = 1'b0;
      end
      #1;
      if (M_AXI_wvalid && M_AXI_wready && M_AXI_wlast) b_pending = 1'b1;
      if (M_AXI_bvalid && M_AXI_bready) b_acc = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every W beat and checks AW/B against the ring model.
  int mon_aw = 0;
  int mon_w = 0;
  int mon_b = 0;
  bit exp_err = 1'b0;
  bit prev_aw_wait = 1'b0;
  bit prev_w_wait = 1'b0;
  bit chk_idx = 1'b0;
  logic [31:0] prev_awaddr = '0;
  logic [31:0] prev_wdata = '0;
  always begin
    @(negedge aclk);
    #2;
    if (areset) begin
      mon_aw = 0;
      mon_w = 0;
      mon_b = 0;
      exp_err = 1'b0;
      prev_aw_wait = 1'b0;
      prev_w_wait = 1'b0;
      chk_idx = 1'b0;
      exp_rd = exp_wr;
    end else begin
      if (chk_idx) begin
        chk("write_index_commit", write_index, ring_word(mon_b));
        chk("error_sticky", error, exp_err);
        chk_idx = 1'b0;
      end
      if (prev_aw_wait) begin
        chk("awvalid_held", M_AXI_awvalid, 1);
        chk("awaddr_stable", M_AXI_awaddr, prev_awaddr);
      end
      if (prev_w_wait) begin
        chk("wvalid_held", M_AXI_wvalid, 1);
        chk("wdata_stable", M_AXI_wdata, prev_wdata);
      end
      if (M_AXI_awvalid && M_AXI_awready) begin
        chk("awaddr", M_AXI_awaddr, base_address + (ring_word(mon_aw) << 2));
        chk("aw_static", {M_AXI_awid, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awcache},
            {6'd0, 4'd15, 3'd2, 2'b01, 4'b0011});
        mon_aw++;
      end
      if (M_AXI_wvalid && M_AXI_wready) begin
        if (exp_rd == exp_wr) begin
          chk("w_beat_without_input", 1, 0);
        end else begin
          chk("wdata", M_AXI_wdata, exp_mem[exp_rd % 4096]);
          exp_rd++;
        end
        chk("wlast", M_AXI_wlast, (mon_w % 16) == 15);
        chk("w_static", {M_AXI_wstrb, M_AXI_wid}, {4'hF, 6'd0});
        mon_w++;
      end
      if (M_AXI_bvalid && M_AXI_bready) begin
        mon_b++;
        exp_err = exp_err | (M_AXI_bresp != 2'b00);
        chk_idx = 1'b1;
      end
      prev_aw_wait = M_AXI_awvalid && !M_AXI_awready;
      prev_awaddr = M_AXI_awaddr;
      prev_w_wait = M_AXI_wvalid && !M_AXI_wready;
      prev_wdata = M_AXI_wdata;
    end
  end

  task automatic wait_b(input int n);
    int t = 0;
    while (mon_b < n && t < 4000) begin
      @(negedge aclk);
      t++;
    end
    chk("burst_count_reached", mon_b >= n, 1);
    #3;
  endtask

  task automatic reset_outputs_check();
    chk("rst_outputs", {S_AXIS_tready, M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, error}, 5'b0);
    chk("rst_write_index", write_index, 0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #3;
    areset = 1'b1;
    enable = 1'b0;
    #1;
    reset_outputs_check();
    repeat (3) @(negedge aclk);
    #3;
    src_total = src_sent;
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    #3;
    chk("tready_after_reset", S_AXIS_tready, 1);
    enable = 1'b1;
  endtask

  initial begin
    int base_sent;
    int start_aw;
    int t;

    // 1) single burst of 1..16
    do_reset();
    src_total = src_sent + 16;
    wait_b(1);
    chk("t1_index", write_index, 16);
    chk("t1_beats", mon_w, 16);

    // 2) 20 bursts with wrap in a 256-word ring
    do_reset();
    src_rand = 1'b1;
    src_gap_pct = 20;
    src_total = src_sent + 320;
    wait_b(20);
    chk("t2_index", write_index, 64);
    chk("t2_aw_count", mon_aw, 20);

    // 3) sparse ready on AW and W
    aw_pct = 30;
    w_pct = 30;
    src_total = src_sent + 64;
    wait_b(24);
    chk("t3_index", write_index, 128);
    aw_pct = 100;
    w_pct = 100;

    // 4) W stalled: FIFO fills to 64 then backpressures without loss
    w_hold = 1'b1;
    src_gap_pct = 0;
    base_sent = src_sent;
    src_total = src_sent + 128;
    t = 0;
    while (S_AXIS_tready && t < 500) begin
      @(negedge aclk);
      t++;
    end
    repeat (10) @(negedge aclk);
    #3;
    chk("t4_accepted_at_full", src_sent - base_sent, 64);
    chk("t4_tready_low", S_AXIS_tready, 0);
    w_hold = 1'b0;
    wait_b(32);
    chk("t4_index", write_index, 0);

    // 5) SLVERR on the second burst of this group
    err_burst = slv_bursts + 2;
    src_total = src_sent + 48;
    wait_b(35);
    chk("t5_error", error, 1);
    chk("t5_index", write_index, 48);
    err_burst = -1;

    // 6a) enable dropped during burst 2 DATA
    start_aw = mon_aw;
    src_total = src_sent + 48;
    t = 0;
    while (!(mon_aw >= start_aw + 2 && M_AXI_wvalid) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    #3;
    enable = 1'b0;
    wait_b(37);
    repeat (30) @(negedge aclk);
    #3;
    chk("t6_no_new_burst", mon_aw, start_aw + 2);
    chk("t6_idle_awvalid", M_AXI_awvalid, 0);
    chk("t6_index", write_index, 80);
    enable = 1'b1;
    wait_b(38);
    chk("t6_resume_index", write_index, 96);
    chk("t6_error_still_set", error, 1);

    // 6b) reset in the middle of a burst
    w_pct = 20;
    src_total = src_sent + 32;
    t = 0;
    while (!(M_AXI_wvalid && (mon_w % 16) >= 3) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    w_pct = 100;
    do_reset();
    chk("t6_fresh_beats", mon_w, 0);

    // clamp: log_length below log2(16) behaves as a 16-word ring
    enable = 1'b0;
    @(negedge aclk);
    #3;
    log_length = 5'd2;
    enable = 1'b1;
    src_total = src_sent + 32;
    wait_b(2);
    chk("clamp_index", write_index, 0);
    chk("clamp_aw_count", mon_aw, 2);

    repeat (5) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
